// File: rtl/lift_call_panel.sv
// lift_call_panel: latches hall/car button presses into pending calls, lights
// the floor lamps, and offers each pending call once to the lift controller
// over a valid/ack handshake in round-robin floor order.
//
// Handshake: req_valid rises with req_floor loaded, and both hold steady until
// req_ack is sampled high on a clock edge. That edge completes the transfer.
// req_valid then drops for at least one GAP cycle before the next offer.
// req_ack is ignored while req_valid is low.
module lift_call_panel #(
  parameter int FLOORS  = 64,
  parameter int FLOOR_W = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOORS-1:0]  button,
  input  logic [FLOOR_W-1:0] current_floor,
  input  logic               stop,
  input  logic               door,
  output logic [FLOOR_W-1:0] req_floor,
  output logic               req_valid,
  input  logic               req_ack,
  output logic [FLOORS-1:0]  pending,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [FLOOR_W-1:0] LAST_FLOOR = FLOOR_W'(FLOORS - 1);

  state_t             state_q, state_d;
  logic [FLOORS-1:0]  btn_q;
  logic [FLOORS-1:0]  pending_q, pending_d;
  logic [FLOORS-1:0]  sent_q, sent_d;
  logic [FLOOR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [FLOOR_W-1:0] req_floor_q, req_floor_d;
  logic               req_valid_q, req_valid_d;

  logic [FLOORS-1:0]  rise;
  logic [FLOORS-1:0]  clr_vec;
  logic [FLOORS-1:0]  req_oh;
  logic [FLOORS-1:0]  cand;
  logic [FLOOR_W-1:0] pick_hi, pick_lo, pick;
  logic               found_hi, found_lo;
  logic               set_sent;

  assign rise = button & ~btn_q;
  assign cand = pending_q & ~sent_q;

  // Decode the service clear and the offered floor as one-hot vectors.
  // Floor numbers at or above FLOORS match no bit, so they are ignored.
  always_comb begin
    clr_vec = '0;
    req_oh  = '0;
    for (int f = 0; f < FLOORS; f++) begin
      if (stop && door && (current_floor == FLOOR_W'(f))) clr_vec[f] = 1'b1;
      if (req_floor_q == FLOOR_W'(f)) req_oh[f] = 1'b1;
    end
  end

  // Round-robin pick: lowest candidate at or above rr_ptr, else lowest overall.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int f = 0; f < FLOORS; f++) begin
      if (cand[f]) begin
        if (!found_lo) begin
          pick_lo  = FLOOR_W'(f);
          found_lo = 1'b1;
        end
        if (!found_hi && (FLOOR_W'(f) >= rr_ptr_q)) begin
          pick_hi  = FLOOR_W'(f);
          found_hi = 1'b1;
        end
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end

  // Call bookkeeping: a clear beats a same-cycle press, and an accepted offer
  // is marked sent only if its call is still pending after this cycle's clear.
  always_comb begin
    pending_d = (pending_q | rise) & ~clr_vec;
    sent_d    = sent_q & ~clr_vec;
    if (set_sent) sent_d = sent_d | (req_oh & pending_d);
  end

  // Offer FSM: next state and handshake register updates.
  always_comb begin
    state_d     = state_q;
    req_floor_d = req_floor_q;
    req_valid_d = req_valid_q;
    rr_ptr_d    = rr_ptr_q;
    set_sent    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found_lo) begin
          req_floor_d = pick;
          req_valid_d = 1'b1;
          state_d     = S_OFFER;
        end
      end
      S_OFFER: begin
        if (req_ack) begin
          set_sent    = 1'b1;
          req_valid_d = 1'b0;
          rr_ptr_d    = (req_floor_q == LAST_FLOOR) ? '0 : req_floor_q + 1'b1;
          state_d     = S_GAP;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        req_valid_d = 1'b0;
      end
    endcase
  end

  // State and data registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      btn_q       <= '0;
      pending_q   <= '0;
      sent_q      <= '0;
      rr_ptr_q    <= '0;
      req_floor_q <= '0;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      btn_q       <= button;
      pending_q   <= pending_d;
      sent_q      <= sent_d;
      rr_ptr_q    <= rr_ptr_d;
      req_floor_q <= req_floor_d;
      req_valid_q <= req_valid_d;
    end
  end

  assign req_floor = req_floor_q;
  assign req_valid = req_valid_q;
  assign pending   = pending_q;
  assign busy      = |pending_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lift_call_panel.sv
// Testbench for lift_call_panel: directed scenarios plus random traffic,
// every cycle compared against a call-level reference model.
module tb_lift_call_panel;

  localparam int FLOORS  = 64;
  localparam int FLOOR_W = 7;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [FLOORS-1:0]  button;
  logic [FLOOR_W-1:0] current_floor;
  logic               stop, door, req_ack;
  logic [FLOOR_W-1:0] req_floor;
  logic               req_valid;
  logic [FLOORS-1:0]  pending;
  logic               busy;
  logic [1:0]         dbg_state;

  lift_call_panel #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .button       (button),
    .current_floor(current_floor),
    .stop         (stop),
    .door         (door),
    .req_floor    (req_floor),
    .req_valid    (req_valid),
    .req_ack      (req_ack),
    .pending      (pending),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard / counters ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [FLOOR_W-1:0] exp_q[$];   // floors the model expects to be offered, in order
  logic prev_valid = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Call-level view: a set of lit floors, a set of already-issued floors,
  // at most one outstanding offer, a gap counter and a rotating start point.
  logic [FLOORS-1:0] m_pend, m_sent, m_prev;
  int m_floor, m_ptr, m_gap;
  bit m_valid;

  task automatic model_reset();
    m_pend = '0; m_sent = '0; m_prev = '0;
    m_floor = 0; m_ptr = 0; m_gap = 0; m_valid = 0;
    exp_q.delete();
    prev_valid = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs present right now.
  task automatic model_step();
    int cf, pick, f;
    logic [FLOORS-1:0] np;
    pick = -1;
    if (!m_valid && m_gap == 0) begin
      for (int i = 0; i < FLOORS; i++) begin
        f = (m_ptr + i) % FLOORS;
        if (pick < 0 && m_pend[f] && !m_sent[f]) pick = f;
      end
    end
    cf = (stop && door && int'(current_floor) < FLOORS) ? int'(current_floor) : -1;
    np = m_pend | (button & ~m_prev);
    if (cf >= 0) begin
      np[cf] = 1'b0;
      m_sent[cf] = 1'b0;
    end
    if (m_valid) begin
      if (req_ack) begin
        if (np[m_floor]) m_sent[m_floor] = 1'b1;
        m_valid = 0;
        m_ptr = (m_floor + 1) % FLOORS;
        m_gap = 1;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (pick >= 0) begin
      m_floor = pick;
      m_valid = 1;
      exp_q.push_back(FLOOR_W'(pick));
    end
    m_pend = np;
    m_prev = button;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic [FLOOR_W-1:0] e;
    model_step();
    @(posedge clk);
    #1;
    chk("req_valid", req_valid, m_valid);
    chk("req_floor", req_floor, m_floor);
    chk("pending", pending, m_pend);
    chk("busy", busy, |m_pend);
    if (req_valid && !prev_valid) begin
      if (exp_q.size() == 0) chk("offer_unexpected", req_floor, 64'hFFFF);
      else begin
        e = exp_q.pop_front();
        chk("offer_order", req_floor, e);
      end
    end
    prev_valid = req_valid;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input int f);
    button[f] = 1'b1;
    tick();
    button[f] = 1'b0;
  endtask

  task automatic retire(input int f);
    current_floor = FLOOR_W'(f);
    stop = 1'b1;
    door = 1'b1;
    tick();
    stop = 1'b0;
    door = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int idx;
    button = '0; current_floor = '0; stop = 0; door = 0; req_ack = 0;
    reset = 1'b1;
    model_reset();
    #12;
    chk("rst_valid", req_valid, 0);
    chk("rst_floor", req_floor, 0);
    chk("rst_pending", pending, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    ticks(2);

    // Single call, offer held while ack is low.
    press(5);
    chk("single_pend5", pending[5], 1);
    tick();
    chk("single_valid", req_valid, 1);
    chk("single_floor", req_floor, 5);
    ticks(4);
    chk("single_hold", req_floor, 5);
    req_ack = 1'b1;
    tick();
    chk("single_ackdrop", req_valid, 0);
    req_ack = 1'b0;
    ticks(3);
    chk("single_no_reoffer", req_valid, 0);

    // Round robin with immediate acks, then wrap from 61 to 2.
    req_ack = 1'b1;
    button[3] = 1; button[10] = 1; button[60] = 1;
    tick();
    button = '0;
    ticks(10);
    press(2);
    ticks(4);
    req_ack = 1'b0;

    // Retire everything, then a fresh press of 10 is offered again.
    retire(5); retire(3); retire(10); retire(60); retire(2);
    chk("retire_busy", busy, 0);
    req_ack = 1'b1;
    press(10);
    tick();
    chk("repress_floor", req_floor, 10);
    ticks(3);
    retire(10);

    // Press at the floor being served is dropped; out-of-range floor ignored.
    current_floor = 7; stop = 1; door = 1; button[7] = 1;
    tick();
    stop = 0; door = 0;
    ticks(3);
    button[7] = 0;
    chk("samefloor_pend7", pending[7], 0);
    press(40);
    ticks(4);
    current_floor = 100; stop = 1; door = 1;
    ticks(2);
    stop = 0; door = 0;
    chk("oob_pend40", pending[40], 1);
    retire(40);

    // Held button yields one call; re-press after service gives another.
    button[20] = 1;
    ticks(20);
    button[20] = 0;
    tick();
    retire(20);
    press(20);
    ticks(5);
    retire(20);
    req_ack = 1'b0;

    // Asynchronous reset in the middle of an offer.
    press(30);
    press(31);
    ticks(2);
    chk("async_pre_valid", req_valid, 1);
    #3 reset = 1'b1;
    #1;
    chk("async_valid", req_valid, 0);
    chk("async_pending", pending, 0);
    chk("async_busy", busy, 0);
    model_reset();
    button = '0;
    #2 reset = 1'b0;
    ticks(6);
    chk("async_no_offer", req_valid, 0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        idx = $urandom_range(0, FLOORS - 1);
        button[idx] = ~button[idx];
      end
      if ($urandom_range(0, 15) == 0) button = '0;
      req_ack = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 3) == 0);
      door = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 2))
        0: current_floor = FLOOR_W'(m_floor);
        1: current_floor = FLOOR_W'($urandom_range(0, FLOORS - 1));
        default: current_floor = FLOOR_W'($urandom_range(0, 127));
      endcase
      tick();
    end
    chk("offq_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/lift_call_panel.md
# lift_call_panel

Call-button front end for the lift controller: it sits between the per-floor hall/car buttons and the controller's `req_floor` input. It latches button presses into pending calls and drives the floor lamps. It issues each pending call to the controller exactly once over a valid/ack handshake, using round-robin floor order. It retires a call when the car reports it is stopped with the door open at that floor.

## Interface
Parameters:
- `FLOORS`, default 64: number of floors (buttons/lamps).
- `FLOOR_W`, default 7: width of floor numbers; must satisfy 2^FLOOR_W >= FLOORS.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `button`  in  FLOORS  level call buttons, one per floor; already debounced and synchronous to `clk`.
- `current_floor`  in  FLOOR_W  car position from the controller.
- `stop`  in  1  car stopped (controller status).
- `door`  in  1  door open (controller status).
- `req_floor`  out  FLOOR_W  floor number being offered to the controller.
- `req_valid`  out  1  `req_floor` is a valid offer.
- `req_ack`  in  1  controller has accepted the offer.
- `pending`  out  FLOORS  lamp per floor; 1 = call outstanding.
- `busy`  out  1  OR-reduction of `pending`.

## Operation
- Press detection: `btn_q` registers `button`. `rise = button & ~btn_q`. Each `rise[f]` sets `pending[f]`. A held button produces one call only.
- Service clear: when `stop & door` and `current_floor < FLOORS`, `pending[current_floor]` and `sent[current_floor]` are cleared. The clear has priority over a same-cycle press at that floor, so the press is dropped. `current_floor >= FLOORS` is ignored.
- `sent[FLOORS]` (internal): marks calls already issued. Candidates are `pending & ~sent`.
- Arbiter: round-robin pointer `rr_ptr` (FLOOR_W bits, range 0..FLOORS-1). It picks the lowest candidate index >= `rr_ptr`, wrapping to 0 if none.
- FSM states and transitions:
  - IDLE: if any candidate exists, register the pick into `req_floor`, set `req_valid`, and go to OFFER. Otherwise stay.
  - OFFER: `req_floor` and `req_valid` are held stable until `req_ack`. On `req_ack`:
    - `sent[req_floor]` is set only if `pending[req_floor]` survives this cycle's clear.
    - `req_valid` is cleared.
    - `rr_ptr` becomes `req_floor+1`, wrapping FLOORS-1 to 0.
    - Go to GAP.
  - OFFER is not withdrawn if the offered floor is cleared meanwhile. The controller treats an already-served floor as a no-op.
  - GAP: one cycle with `req_valid=0`, so consecutive offers are distinct events at the controller. Then go to IDLE.
- `req_ack` outside OFFER is ignored.
- `busy` is combinational from `pending`.

## Timing
- Reset values: `req_floor=0`, `req_valid=0`, `pending=0`, `busy=0`, `sent=0`, `btn_q=0`, `rr_ptr=0`, state IDLE.
- Reset is asynchronous: outputs go to their reset values without a clock edge. Reset mid-OFFER drops `req_valid` immediately and discards all calls.
- `button[f]` first sampled high at edge k: `pending[f]=1` after edge k, and `req_valid=1` after edge k+1 if the arbiter selects f.
- Ack sampled at edge a: `req_valid=0` after a, GAP during cycle a+1, and the next offer earliest after edge a+2. Maximum throughput is one call per 3 cycles.
- Service clear: `stop & door` at edge c gives `pending[current_floor]=0` after c.
- Wrap-around: `rr_ptr` at FLOORS-1 with the only candidate at floor 0 selects floor 0.

## Test plan
- Single call: reset, pulse `button[5]` for 1 cycle, hold `req_ack=0` for 4 cycles.
  -> `pending[5]=1` after 1 edge; `req_valid=1`, `req_floor=5` after 2 edges, stable for all 4 cycles.
  -> Assert `req_ack` -> `req_valid=0` next edge, `sent[5]=1`.
- Round-robin: press floors 3, 10 and 60 in one cycle, ack each offer immediately.
  -> Offers are 3, 10, 60, each 3 cycles apart.
  -> Then press floor 2 -> `rr_ptr` wraps from 61 and offers 2.
- Retire: with floor 10 sent, drive `current_floor=10`, `stop=1`, `door=1` for 1 cycle.
  -> `pending[10]=0` next edge; `busy=0` if it was the last call.
  -> A later press of 10 -> new offer of 10.
- Same-floor press: press `button[7]` while `current_floor=7`, `stop=door=1`.
  -> `pending[7]` stays 0 and no offer is made.
  -> `current_floor=100` with `stop=door=1` -> no effect.
- Held button: hold `button[20]` high for 20 cycles.
  -> Exactly one offer of 20. Release and press again after service -> a second offer.
- Async reset: assert `reset` mid-OFFER between clock edges.
  -> `req_valid=0`, `pending=0`, `busy=0` immediately.
  -> After release, no offer until a new press.
